// File: rtl/cpu_pkg.sv
// Shared types and opcode constants for the lab CPU sequencer.
package cpu_pkg;

  localparam int OP_W    = 4;
  localparam int INSTR_W = 16;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_MEM    = 3'd4,
    ST_WB     = 3'd5,
    ST_HALT   = 3'd6
  } seq_state_t;

  localparam logic [OP_W-1:0] OP_LOAD  = 4'b0000;
  localparam logic [OP_W-1:0] OP_STORE = 4'b0001;
  localparam logic [OP_W-1:0] OP_BEQ   = 4'b1010;
  localparam logic [OP_W-1:0] OP_BNE   = 4'b1011;
  localparam logic [OP_W-1:0] OP_HALT  = 4'b1111;

  // 1100..1110 are reserved; 1111 is HALT
  function automatic logic is_illegal(input logic [OP_W-1:0] op);
    return (op >= 4'b1100) && (op != OP_HALT);
  endfunction

  function automatic logic is_branch(input logic [OP_W-1:0] op);
    return (op == OP_BEQ) || (op == OP_BNE);
  endfunction

  function automatic logic branch_taken(input logic [OP_W-1:0] op, input logic zero);
    return (op == OP_BEQ) ? zero : !zero;
  endfunction

endpackage

// File: rtl/cpu_sequencer_if.sv
// Instruction and data memory handshake bundle between the sequencer and the memories.
interface cpu_sequencer_if
  import cpu_pkg::*;
#(
  parameter int PC_W = 8
);

  logic               imem_req;
  logic [PC_W-1:0]    imem_addr;
  logic               imem_ack;
  logic [INSTR_W-1:0] imem_rdata;
  logic               dmem_req;
  logic               dmem_we;
  logic               dmem_ack;

  modport master (
    output imem_req, imem_addr, dmem_req, dmem_we,
    input  imem_ack, imem_rdata, dmem_ack
  );

  modport slave (
    input  imem_req, imem_addr, dmem_req, dmem_we,
    output imem_ack, imem_rdata, dmem_ack
  );

endinterface

// File: rtl/cpu_sequencer_branch_target.sv
// Branch target adder: pc + 1 + sign-extended 9-bit offset, wrapping at PC_W bits.
module branch_target #(
  parameter int PC_W = 8
) (
  input  logic [PC_W-1:0] pc_i,
  input  logic [8:0]      offset_i,
  output logic [PC_W-1:0] target_o
);

  // Resizing the signed offset to PC_W either sign-extends or truncates; both are exact modulo 2^PC_W.
  assign target_o = pc_i + PC_W'(1) + PC_W'($signed(offset_i));

endmodule

// File: rtl/cpu_sequencer.sv
// Multi-cycle control FSM for the 16-bit lab CPU: owns pc/ir, memory handshakes, strobes, retire count.
// States: IDLE wait for run | FETCH imem handshake | DECODE settle | EXEC dispatch | MEM dmem handshake | WB reg write | HALT parked
module cpu_sequencer
  import cpu_pkg::*;
#(
  parameter int PC_W  = 8,
  parameter int CNT_W = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                run_i,
  cpu_sequencer_if.master     mem_if,
  output logic [INSTR_W-1:0]  ir_o,
  input  logic                dec_regwrite_i,
  input  logic                dec_memwrite_i,
  input  logic                alu_zero_i,
  output logic                reg_we_o,
  output logic [PC_W-1:0]     pc_o,
  output logic [2:0]          state_o,
  output logic                halted_o,
  output logic                illegal_op_o,
  output logic [CNT_W-1:0]    retired_o
);

  seq_state_t         state_q, state_d;
  logic [PC_W-1:0]    pc_q, pc_d;
  logic [PC_W-1:0]    pc_inc;
  logic [PC_W-1:0]    br_target;
  logic [INSTR_W-1:0] ir_q, ir_d;
  logic [CNT_W-1:0]   retired_q, retired_d;
  logic               halted_q, halted_d;
  logic               illegal_q, illegal_d;
  logic [OP_W-1:0]    opcode;
  logic               retire;

  assign opcode = ir_q[INSTR_W-1 -: OP_W];
  assign pc_inc = pc_q + PC_W'(1);

  branch_target #(.PC_W(PC_W)) u_branch_target (
    .pc_i     (pc_q),
    .offset_i (ir_q[8:0]),
    .target_o (br_target)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      pc_q      <= '0;
      ir_q      <= '0;
      retired_q <= '0;
      halted_q  <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      ir_q      <= ir_d;
      retired_q <= retired_d;
      halted_q  <= halted_d;
      illegal_q <= illegal_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    ir_d      = ir_q;
    retired_d = retired_q;
    halted_d  = halted_q;
    illegal_d = illegal_q;
    retire    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (run_i) state_d = ST_FETCH;
      end
      ST_FETCH: begin
        if (mem_if.imem_ack) begin
          ir_d    = mem_if.imem_rdata;
          state_d = ST_DECODE;
        end
      end
      ST_DECODE: begin
        state_d = ST_EXEC;
      end
      ST_EXEC: begin
        if ((opcode == OP_LOAD) || (opcode == OP_STORE)) begin
          state_d = ST_MEM;
        end else if (is_branch(opcode)) begin
          pc_d   = branch_taken(opcode, alu_zero_i) ? br_target : pc_inc;
          retire = 1'b1;
        end else if (opcode == OP_HALT) begin
          state_d  = ST_HALT;
          halted_d = 1'b1;
          retire   = 1'b1;
        end else if (is_illegal(opcode)) begin
          illegal_d = 1'b1;
          pc_d      = pc_inc;
          retire    = 1'b1;
        end else begin
          state_d = ST_WB;
        end
      end
      ST_MEM: begin
        if (mem_if.dmem_ack) begin
          if (opcode == OP_STORE) begin
            pc_d   = pc_inc;
            retire = 1'b1;
          end else begin
            state_d = ST_WB;
          end
        end
      end
      ST_WB: begin
        pc_d   = pc_inc;
        retire = 1'b1;
      end
      ST_HALT: begin
        state_d = ST_HALT;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // run is only looked at on an instruction boundary; HALT keeps its own successor
    if (retire) begin
      retired_d = retired_q + CNT_W'(1);
      if (state_d != ST_HALT) state_d = run_i ? ST_FETCH : ST_IDLE;
    end
  end

  assign mem_if.imem_req  = (state_q == ST_FETCH);
  assign mem_if.imem_addr = pc_q;
  assign mem_if.dmem_req  = (state_q == ST_MEM);
  assign mem_if.dmem_we   = (state_q == ST_MEM) && dec_memwrite_i;
  assign reg_we_o         = (state_q == ST_WB) && dec_regwrite_i;

  assign ir_o         = ir_q;
  assign pc_o         = pc_q;
  assign state_o      = state_q;
  assign halted_o     = halted_q;
  assign illegal_op_o = illegal_q;
  assign retired_o    = retired_q;

  a_req_exclusive: assert property (@(posedge clk) disable iff (!rst_n)
    !(mem_if.imem_req && mem_if.dmem_req));

endmodule

// File: doc/cpu_sequencer.md
Name: cpu_sequencer

Overview:
- Multi-cycle control FSM for the 16-bit lab CPU.
- Owns the PC and the instruction register, and handshakes with instruction and data memory.
- Gates the instruction decoder's control outputs into single-cycle strobes (register write, memory write), resolves branches, and counts retired instructions.
- Sits between the memories and the decoder/register-file/ALU datapath.

Parameters:
- PC_W, 8: PC / imem address width.
- CNT_W, 16: retired-instruction counter width.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- run  in  1  level; 1 = execute, 0 = stop at the next instruction boundary.
- imem_req  out  1  instruction fetch request.
- imem_addr  out  PC_W  fetch address (= pc).
- imem_ack  in  1  fetch data valid this cycle.
- imem_rdata  in  16  fetched instruction.
- ir  out  16  instruction register, drives the decoder fields; opcode = ir[15:12].
- dec_regwrite  in  1  decoder RegWrite.
- dec_memwrite  in  1  decoder MemWrite.
- alu_zero  in  1  ALU zero flag, valid in EXEC.
- dmem_req  out  1  data memory request.
- dmem_we  out  1  write qualifier, valid with dmem_req.
- dmem_ack  in  1  data access complete.
- reg_we  out  1  register-file write strobe.
- pc  out  PC_W  program counter.
- state_o  out  3  current state encoding (debug).
- halted  out  1  HALT executed.
- illegal_op  out  1  sticky illegal-opcode flag.
- retired  out  CNT_W  retired-instruction count.

Behaviour:
- **Reset (async, rst_n=0):**
  - State = IDLE; pc = 0; ir = 0; retired = 0.
  - halted = 0, illegal_op = 0.
  - All request/strobe outputs = 0.
  - Reset mid-access aborts immediately; memories must tolerate a dropped request.
- **States:** IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, HALT=6.
- **IDLE:** go to FETCH when run=1.
- **FETCH:**
  - imem_req=1 and imem_addr=pc, held until imem_ack.
  - imem_ack may arrive in the first request cycle.
  - On ack: ir <= imem_rdata, go to DECODE.
- **DECODE:** one cycle for decoder outputs to settle; no strobes; go to EXEC.
- **EXEC:** one cycle; action by opcode:
  - 0000 (load), 0001 (store): go to MEM.
  - 1010 (branch if zero): taken when alu_zero=1.
  - 1011 (branch if not zero): taken when alu_zero=0.
  - Branch target: pc <= pc + 1 + sext(ir[8:0]), truncated to PC_W (wraps modulo 2^PC_W). Not taken: pc <= pc+1. Then retire.
  - 1111 (HALT): go to HALT; pc unchanged; retire.
  - 1100–1110: illegal_op <= 1; treat as NOP (pc <= pc+1, retire).
  - All others: go to WB.
- **MEM:**
  - dmem_req=1 and dmem_we=dec_memwrite, held until dmem_ack.
  - Store, on ack: pc <= pc+1, retire.
  - Load, on ack: go to WB.
- **WB:** reg_we = dec_regwrite for exactly one cycle; pc <= pc+1; retire.
- **Retire:**
  - retired <= retired+1, wrapping.
  - Next state is FETCH if run=1, else IDLE.
  - run is sampled only at retire; a run drop mid-instruction completes that instruction.
- **HALT:** halted=1; stays in HALT until reset; run is ignored.
- **Strobe rules:**
  - reg_we and dmem_req are never asserted outside WB and MEM respectively.
  - imem_req and dmem_req are never asserted together.
- **Minimum latencies (same-cycle ack):**
  - ALU op: 4 cycles.
  - Load: 5 cycles.
  - Store: 4 cycles.
  - Branch / NOP / HALT: 3 cycles.
- **Outputs:** registered, except the request/strobe outputs, which are decoded from state.

Decomposition:
- Shared package cpu_pkg:
  - state enum seq_state_t.
  - Opcode constants OP_LOAD, OP_STORE, OP_BEQ, OP_BNE, OP_HALT.
  - OP_W=4 and INSTR_W=16.
- One sub-module, branch_target: combinational pc+1+sext(offset) with PC_W truncation. The FSM, PC, and counter stay in cpu_sequencer.

Test Plan:
- **Reset and ALU op:** release reset with run=1; imem returns 0x4000 (ALU op) with 0-wait ack → imem_req in cycle 1, reg_we pulses in cycle 4, pc=1, retired=1.
- **Load and store with waits:** load with dmem_ack delayed 3 cycles → dmem_we=0, reg_we only after ack, 8 cycles total. Store → dmem_we=1, reg_we never asserted, pc+1.
- **Branches:**
  - At pc=10, 1010 with offset 9'h1FC (−4) and alu_zero=1 → pc=7.
  - Same instruction with alu_zero=0 → pc=11.
  - At pc=250, 1011 with offset +10 and alu_zero=0 → pc=5 (wrap).
- **Run control and HALT:**
  - Drop run during MEM → access completes, then IDLE with no further imem_req.
  - HALT opcode 0xF000 → halted=1, pc frozen, no requests for 20 cycles even with run=1.
- **Illegal opcode:** 0xC000 → illegal_op=1 and stays set, pc+1, no strobes; the next instruction executes normally.
- **Async reset mid-fetch:** assert rst_n=0 mid-fetch with imem_ack pending → all outputs 0 immediately, and pc=0 after release.
